bus_ctrl_l2_block_adapter: RTL and testbench

//   Downstream stage of the coherence bus controller: converts one block-wide L2 request
//   (BLOCK_SIZE_WORDS words) into sequential single-word transfers on the L2 generic bus.

---
 rtl/bus_ctrl_l2_block_adapter_if.sv | 32 +++
 rtl/bus_ctrl_l2_block_adapter.sv | 132 +++++++++++++
 tb/tb_bus_ctrl_l2_block_adapter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_ctrl_l2_block_adapter_if.sv
// Signal bundle between the coherence bus controller L2 port, the block adapter and the L2 bus.
// slave: adapter view (accepts block requests, drives word strobes); master: environment view.
interface bus_ctrl_l2_block_adapter_if #(
   parameter int unsigned BLOCK_SIZE_WORDS = 2,
   parameter int unsigned WORD_W           = 32,
   parameter int unsigned ADDR_W           = 32
);
   logic                               bus_ren;
   logic                               bus_wen;
   logic [ADDR_W-1:0]                  bus_addr;
   logic [BLOCK_SIZE_WORDS*WORD_W-1:0] bus_wdata;
   logic [BLOCK_SIZE_WORDS*WORD_W-1:0] bus_rdata;
   logic                               bus_done;
   logic                               bus_busy;
   logic                               bus_error;
   logic                               l2_ren;
   logic                               l2_wen;
   logic [ADDR_W-1:0]                  l2_addr;
   logic [WORD_W-1:0]                  l2_wdata;
   logic [WORD_W-1:0]                  l2_rdata;
   logic                               l2_busy;

   modport slave (
      input  bus_ren, bus_wen, bus_addr, bus_wdata, l2_rdata, l2_busy,
      output bus_rdata, bus_done, bus_busy, bus_error, l2_ren, l2_wen, l2_addr, l2_wdata
   );

   modport master (
      output bus_ren, bus_wen, bus_addr, bus_wdata, l2_rdata, l2_busy,
      input  bus_rdata, bus_done, bus_busy, bus_error, l2_ren, l2_wen, l2_addr, l2_wdata
   );
endinterface

// File: rtl/bus_ctrl_l2_block_adapter.sv
// Splits one block-wide L2 request into sequential word transfers and reassembles read blocks.
// Define L2_TIMEOUT_EN to add a per-word watchdog that abandons a stalled block with bus_error.
module bus_ctrl_l2_block_adapter #(
   parameter int unsigned BLOCK_SIZE_WORDS = 2,
   parameter int unsigned WORD_W           = 32,
   parameter int unsigned ADDR_W           = 32,
   parameter int unsigned L2_TIMEOUT       = 50
) (
   input logic                        CLK,
   input logic                        nRST,
   bus_ctrl_l2_block_adapter_if.slave bif
);
   localparam int unsigned      BLK_W      = BLOCK_SIZE_WORDS * WORD_W;
   localparam int unsigned      CNT_W      = (BLOCK_SIZE_WORDS > 1) ? $clog2(BLOCK_SIZE_WORDS) : 1;
   localparam int unsigned      OFF_BITS   = $clog2(BLK_W / 8);
   localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_BITS) - 64'd1);
   localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(WORD_W / 8);
   localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(BLOCK_SIZE_WORDS - 1);

   if (BLOCK_SIZE_WORDS == 0 || (BLOCK_SIZE_WORDS & (BLOCK_SIZE_WORDS - 1)) != 0) begin : g_bad_block
      $error("BLOCK_SIZE_WORDS must be a non-zero power of two");
   end
   if (L2_TIMEOUT < 1) begin : g_bad_timeout
      $error("L2_TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t             state, state_nxt;
   logic [ADDR_W-1:0]  base_q;
   logic [BLK_W-1:0]   wdata_q;
   logic [BLK_W-1:0]   rdata_q;
   logic               op_wr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               start;
   logic               word_ok;
   logic               last_word;
   logic               timeout;
   logic               l2_ren_c, l2_wen_c;
   logic [ADDR_W-1:0]  l2_addr_c;
   logic [WORD_W-1:0]  l2_wdata_c;

   assign start     = bif.bus_ren | bif.bus_wen;
   assign word_ok   = (state == XFER) & ~bif.l2_busy;
   assign last_word = (cnt_q == LAST_WORD);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      l2_ren_c   = 1'b0;
      l2_wen_c   = 1'b0;
      l2_addr_c  = '0;
      l2_wdata_c = '0;
      case (state)
         IDLE: if (start) state_nxt = XFER;
         XFER: begin
            l2_ren_c  = ~op_wr_q;
            l2_wen_c  = op_wr_q;
            l2_addr_c = base_q + ADDR_W'(cnt_q) * WORD_BYTES;
            if (op_wr_q) l2_wdata_c = wdata_q[cnt_q*WORD_W +: WORD_W];
            if ((word_ok && last_word) || timeout) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         base_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         op_wr_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               base_q  <= bif.bus_addr & ~OFF_MASK;
               wdata_q <= bif.bus_wdata;
               op_wr_q <= bif.bus_wen;
               cnt_q   <= '0;
            end
            XFER: if (word_ok) begin
               if (!op_wr_q) rdata_q[cnt_q*WORD_W +: WORD_W] <= bif.l2_rdata;
               if (!last_word) cnt_q <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef L2_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(L2_TIMEOUT + 1);

   logic [WD_W-1:0] wdog_q;
   logic            err_q;

   assign timeout = (state == XFER) & bif.l2_busy & (wdog_q == WD_W'(L2_TIMEOUT - 1));

   // err_q is set on the edge into DONE and cleared on the edge out of it.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else if (state == XFER) begin
         if (word_ok) wdog_q <= '0;
         else         wdog_q <= wdog_q + 1'b1;
         if (timeout) err_q <= 1'b1;
      end else begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end
   end

   assign bif.bus_error = err_q;
`else
   assign timeout       = 1'b0;
   assign bif.bus_error = 1'b0;
`endif

   assign bif.bus_rdata = rdata_q;
   assign bif.bus_done  = (state == DONE);
   assign bif.bus_busy  = (state != IDLE);
   assign bif.l2_ren    = l2_ren_c;
   assign bif.l2_wen    = l2_wen_c;
   assign bif.l2_addr   = l2_addr_c;
   assign bif.l2_wdata  = l2_wdata_c;
endmodule

// File: tb/tb_bus_ctrl_l2_block_adapter.sv
// Scoreboard bench for the L2 block adapter: driver pushes expected word beats and completions,
// a negedge monitor plays the L2 memory and compares every strobe cycle and every done pulse.
module tb_bus_ctrl_l2_block_adapter;
   localparam int unsigned BSW       = 2;
   localparam int unsigned WW        = 32;
   localparam int unsigned AW        = 32;
   localparam int unsigned TMO       = 50;
   localparam int unsigned BLK_BYTES = BSW * WW / 8;

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   always #5 CLK = ~CLK;

   bus_ctrl_l2_block_adapter_if #(.BLOCK_SIZE_WORDS(BSW), .WORD_W(WW), .ADDR_W(AW)) bif ();

   bus_ctrl_l2_block_adapter #(
      .BLOCK_SIZE_WORDS(BSW), .WORD_W(WW), .ADDR_W(AW), .L2_TIMEOUT(TMO)
   ) dut (
      .CLK(CLK), .nRST(nRST), .bif(bif)
   );

   typedef struct { bit wr; logic [AW-1:0] addr; logic [WW-1:0] wdata; int idx; } beat_t;
   typedef struct { logic [BSW*WW-1:0] rdata; bit err; } done_t;

   beat_t            exp_beats[$];
   done_t            exp_done[$];
   logic [WW-1:0]    ref_mem [logic [AW-1:0]];
   logic [WW-1:0]    l2_mem  [logic [AW-1:0]];
   logic [BSW*WW-1:0] ref_rdata;

   int vectors = 0, miscompares = 0;
   int done_cnt = 0;
   bit zero_wait = 1'b0;
   int fixed_wait = -1;
   int stall_word = -1;
   int stall_left = 0;
   int run = 0;
   bit prev_done = 1'b0;

   function automatic logic [WW-1:0] fill(input logic [AW-1:0] a);
      return WW'(a) ^ 32'hC0DE5A5A;
   endfunction
   function automatic logic [WW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : fill(a);
   endfunction
   function automatic logic [WW-1:0] l2_rd(input logic [AW-1:0] a);
      return l2_mem.exists(a) ? l2_mem[a] : fill(a);
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: word i of the block lives at aligned base + 4*i; a write updates memory,
   // a read replaces the whole returned block; an abandoned word-0 read changes nothing.
   task automatic expect_xfer(input bit wr, input logic [AW-1:0] addr,
                              input logic [BSW*WW-1:0] wdata, input bit err);
      logic [AW-1:0]     base, a;
      logic [BSW*WW-1:0] blk;
      beat_t             b;
      done_t             d;
      base = addr - (addr % BLK_BYTES);
      blk  = '0;
      for (int i = 0; i < int'(BSW); i++) begin
         a       = base + AW'(i * (WW / 8));
         b.wr    = wr;
         b.addr  = a;
         b.wdata = wr ? wdata[i*WW +: WW] : '0;
         b.idx   = i;
         exp_beats.push_back(b);
         if (!err) begin
            if (wr) ref_mem[a] = wdata[i*WW +: WW];
            else    blk[i*WW +: WW] = ref_rd(a);
         end
      end
      if (!wr && !err) ref_rdata = blk;
      d.rdata = ref_rdata;
      d.err   = err;
      exp_done.push_back(d);
   endtask

   task automatic wait_done(output int n, output int sc, output bit saw_ren);
      n = 0; sc = 0; saw_ren = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge CLK);
         n++;
         if (bif.l2_ren || bif.l2_wen) sc++;
         if (bif.l2_ren) saw_ren = 1'b1;
         if (bif.bus_done) return;
      end
      vectors++;
      miscompares++;
      $display("FAIL wait_done: bus_done not seen within 2000 cycles, required a done pulse");
      n = -1;
   endtask

   task automatic run_xfer(input bit rd, input bit wr, input logic [AW-1:0] addr,
                           input logic [BSW*WW-1:0] wdata, input bit err,
                           output int n, output int sc, output bit saw_ren);
      expect_xfer(wr, addr, wdata, err);
      bif.bus_addr  = addr;
      bif.bus_wdata = wdata;
      bif.bus_ren   = rd;
      bif.bus_wen   = wr;
      wait_done(n, sc, saw_ren);
      @(posedge CLK); #1;
      bif.bus_ren = 1'b0;
      bif.bus_wen = 1'b0;
   endtask

   // Monitor and L2 responder: checks the strobe against the expected beat, then decides l2_busy.
   always @(negedge CLK) begin
      beat_t b;
      done_t d;
      bit    strobe, busy;
      if (!nRST) begin
         prev_done    = 1'b0;
         run          = 0;
         bif.l2_busy  = 1'b0;
         bif.l2_rdata = '0;
      end else begin
         if (bif.bus_done) begin
            done_cnt++;
            check("done_single_cycle", prev_done, 0);
            if (exp_done.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL spurious_done: got bus_done=1, required no completion");
            end else begin
               d = exp_done.pop_front();
               check("bus_rdata", bif.bus_rdata, d.rdata);
               check("bus_error", bif.bus_error, d.err);
               check("bus_busy_at_done", bif.bus_busy, 1);
               if (d.err) exp_beats.delete();
            end
         end else begin
            check("bus_error_quiet", bif.bus_error, 0);
         end
         prev_done = bif.bus_done;

         strobe = bif.l2_ren || bif.l2_wen;
         if (strobe) begin
            if (exp_beats.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_strobe: got ren=%0b wen=%0b addr=0x%0h, required none",
                        bif.l2_ren, bif.l2_wen, bif.l2_addr);
            end else begin
               b = exp_beats[0];
               check("l2_op", {bif.l2_ren, bif.l2_wen}, {~b.wr, b.wr});
               check("l2_addr", bif.l2_addr, b.addr);
               if (b.wr) check("l2_wdata", bif.l2_wdata, b.wdata);
            end
            if (exp_beats.size() > 0 && exp_beats[0].idx == stall_word && stall_left > 0) begin
               busy = 1'b1;
               stall_left--;
            end else if (zero_wait)       busy = 1'b0;
            else if (fixed_wait >= 0)     busy = (run < fixed_wait);
            else                          busy = (run < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            run = busy ? run + 1 : 0;
            if (!busy) begin
               if (bif.l2_wen) l2_mem[bif.l2_addr] = bif.l2_wdata;
               if (exp_beats.size() > 0) void'(exp_beats.pop_front());
            end
            bif.l2_busy  = busy;
            bif.l2_rdata = l2_rd(bif.l2_addr);
         end else begin
            run          = 0;
            bif.l2_busy  = 1'($urandom_range(0, 1));
            bif.l2_rdata = $urandom;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int n, sc, dc;
      bit sr, rd, wr, found;
      logic [AW-1:0] addr;
      logic [BSW*WW-1:0] wd;
      bif.bus_ren = 1'b0; bif.bus_wen = 1'b0; bif.bus_addr = '0; bif.bus_wdata = '0;
      ref_rdata = '0;
      #12;
      check("rst_l2_ren", bif.l2_ren, 0);
      check("rst_l2_wen", bif.l2_wen, 0);
      check("rst_bus_busy", bif.bus_busy, 0);
      check("rst_bus_done", bif.bus_done, 0);
      check("rst_bus_rdata", bif.bus_rdata, 0);
      check("rst_bus_error", bif.bus_error, 0);
      @(posedge CLK); #1 nRST = 1'b1;
      @(posedge CLK); #1;

      // Zero-wait read from an unaligned address
      ref_mem[32'h1000] = 32'hAAAA0000; l2_mem[32'h1000] = 32'hAAAA0000;
      ref_mem[32'h1004] = 32'hBBBB0001; l2_mem[32'h1004] = 32'hBBBB0001;
      zero_wait = 1'b1;
      run_xfer(1, 0, 32'h1004, '0, 0, n, sc, sr);
      check("t1_done_latency", n, BSW + 2);
      check("t1_bus_rdata", bif.bus_rdata, 64'hBBBB0001_AAAA0000);

      // Write with three wait cycles per word
      zero_wait = 1'b0; fixed_wait = 3;
      run_xfer(0, 1, 32'h2000, 64'hDEADBEEF_12345678, 0, n, sc, sr);
      check("t2_done_latency", n, BSW * 4 + 2);
      check("t2_mem_word0", l2_rd(32'h2000), 32'h12345678);
      check("t2_mem_word1", l2_rd(32'h2004), 32'hDEADBEEF);
      check("t2_rdata_kept", bif.bus_rdata, 64'hBBBB0001_AAAA0000);

      // Simultaneous read and write request
      fixed_wait = -1;
      wd = {$urandom, $urandom};
      run_xfer(1, 1, 32'h40, wd, 0, n, sc, sr);
      check("t3_no_l2_ren", sr, 0);
      check("t3_mem_word0", l2_rd(32'h40), wd[31:0]);

      // Reset while word 1 of a read is pending
      fixed_wait = 0; stall_word = 1; stall_left = 1000;
      expect_xfer(0, 32'h3008, '0, 0);
      bif.bus_addr = 32'h3008; bif.bus_ren = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge CLK);
         found = bif.l2_ren && (bif.l2_addr == 32'h300C);
      end
      check("t4_word1_pending", found, 1);
      @(posedge CLK); #2;
      nRST = 1'b0; bif.bus_ren = 1'b0;
      #1;
      check("t4_l2_ren_drop", bif.l2_ren, 0);
      check("t4_l2_wen_drop", bif.l2_wen, 0);
      check("t4_bus_busy_drop", bif.bus_busy, 0);
      check("t4_bus_done_low", bif.bus_done, 0);
      exp_beats.delete(); exp_done.delete();
      ref_rdata = '0; stall_word = -1; stall_left = 0;
      dc = done_cnt;
      repeat (3) @(negedge CLK);
      check("t4_no_done", done_cnt, dc);
      check("t4_rdata_cleared", bif.bus_rdata, 0);
      @(posedge CLK); #1 nRST = 1'b1;
      @(posedge CLK); #1;
      zero_wait = 1'b1;
      run_xfer(1, 0, 32'h3008, '0, 0, n, sc, sr);
      check("t4_restart_latency", n, BSW + 2);

      // Word 0 stalled far beyond the watchdog limit
      stall_word = 0; stall_left = 60;
`ifdef L2_TIMEOUT_EN
      run_xfer(1, 0, 32'h5000, '0, 1, n, sc, sr);
      check("t5_strobe_cycles", sc, TMO);
`else
      run_xfer(1, 0, 32'h5000, '0, 0, n, sc, sr);
      check("t5_strobe_cycles", sc, 60 + BSW);
`endif
      stall_word = -1; stall_left = 0;

      // Request held high across two back-to-back reads
      dc = done_cnt;
      expect_xfer(0, 32'h6000, '0, 0);
      expect_xfer(0, 32'h6000, '0, 0);
      bif.bus_addr = 32'h6000; bif.bus_ren = 1'b1;
      wait_done(n, sc, sr);
      @(negedge CLK);
      check("t6_idle_between", bif.bus_busy, 0);
      @(negedge CLK);
      check("t6_restart_next", bif.l2_ren, 1);
      wait_done(n, sc, sr);
      @(posedge CLK); #1 bif.bus_ren = 1'b0;
      repeat (4) @(negedge CLK);
      check("t6_done_pulses", done_cnt - dc, 2);

      // Random traffic with random wait states
      zero_wait = 1'b0;
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 2))
            0:       begin rd = 1'b1; wr = 1'b0; end
            1:       begin rd = 1'b0; wr = 1'b1; end
            default: begin rd = 1'b1; wr = 1'b1; end
         endcase
         addr = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | AW'($urandom_range(0, 15)))
                                             : (32'h7000 + AW'($urandom_range(0, 127)));
         wd = {$urandom, $urandom};
         run_xfer(rd, wr, addr, wd, 0, n, sc, sr);
         if (wr) check("rnd_no_l2_ren", sr, 0);
      end
      repeat (4) @(negedge CLK);
      check("end_beats_drained", exp_beats.size(), 0);
      check("end_done_drained", exp_done.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
